adder_pc4: RTL and testbench
============================

Name: adder_pc4

Overview:
- PC incrementer for the RISC-V fetch stage; produces sequential next-PC (pc + 4) combinationally for the PC mux.
- Also provides status flags (wrap-around, misalignment) and an optional registered copy of the result for pipelined fetch.
- Purely arithmetic; no handshake with memory.

Parameters:
- XLEN, 32, datapath width of pc and pc_next.
- INC, 4, increment constant added to pc; must be below 2^XLEN.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- pc  input  XLEN  current program counter.
- en  input  1  load enable for the registered stage.
- pc_next  output  XLEN  combinational pc + INC, modulo 2^XLEN.
- carry  output  1  combinational; 1 when pc + INC exceeds 2^XLEN-1 and wraps.
- misaligned  output  1  combinational; 1 when pc[1:0] != 2'b00.
- pc_next_q  output  XLEN  registered pc_next.
- carry_q  output  1  registered carry.
- valid_q  output  1  1 once the registered stage has captured at least one value since reset.

Behaviour:
- pc_next = (pc + INC) truncated to XLEN bits. Zero latency. Settles within the same delta/propagation time as pc changes, with no clock dependency.
- carry is bit XLEN of the (XLEN+1)-bit sum. pc_next is the wrapped value.
  - Example: 0xFFFFFFFC gives pc_next 0x00000000 and carry 1.
  - Example: 0xFFFFFFFB gives pc_next 0xFFFFFFFF and carry 0.
- The adder does not fix or block misaligned pc.
  - 0x0000000A gives pc_next 0x0000000E and misaligned = 1.
  - Trap handling belongs to the consumer.
- Combinational outputs ignore clk, rst_n and en. They remain valid during reset.
- Registered stage, on rising clk edge with en = 1:
  - pc_next_q <= pc_next
  - carry_q <= carry
  - valid_q <= 1
- With en = 0, all registered outputs hold their values.
- Asynchronous reset: rst_n low immediately forces pc_next_q = 0, carry_q = 0, valid_q = 0, regardless of clk.
- Reset release: the first capture occurs on the first rising edge with rst_n high and en = 1.
- Reset asserted mid-operation clears the registered state at once and discards any pending capture.
- No X-propagation masking. An X on pc drives X on the combinational outputs.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN default (32)
  - PC_INC constant (4)
  - PC_RESET_VAL constant (0), used for the pc_next_q reset value.
- One natural sub-module, pc_inc_comb: the combinational adder plus the carry and misaligned logic.
- The top level wraps pc_inc_comb with the en-gated register stage.

Test Plan:
- pc = 0x00000000 -> pc_next 0x00000004, carry 0, misaligned 0, all within 1 ns without a clock edge.
- pc = 0x00000004 -> pc_next 0x00000008. pc = 0x0000000A -> pc_next 0x0000000E, misaligned 1.
- pc = 0xFFFFFFFB -> pc_next 0xFFFFFFFF, carry 0. pc = 0xFFFFFFFC -> pc_next 0x00000000, carry 1.
- rst_n low, then pc = 0x100 with en = 1 and clock running -> pc_next_q 0, valid_q 0. After rst_n rises, the first edge gives pc_next_q 0x104 and valid_q 1.
- en = 0 with pc changing 0x200 -> 0x300 across edges -> pc_next_q holds the prior value. en = 1 -> pc_next_q 0x304 on the next edge.
- Drop rst_n asynchronously between edges while pc_next_q = 0x304 -> it clears to 0 immediately, before the next edge. Combinational pc_next keeps tracking pc throughout.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V fetch-stage constants: datapath width, sequential PC step
// and the value the registered next-PC holds while in reset.
package rv_pkg;

    localparam int XLEN         = 32;
    localparam int PC_INC       = 4;
    localparam int PC_RESET_VAL = 0;

endpackage : rv_pkg

// File: rtl/pc_inc_comb.sv
// Combinational PC incrementer: next-PC, wrap-around carry and a
// misalignment flag. The flag is informational only; the sum is produced
// for any pc, and trap handling is left to the consumer.
module pc_inc_comb
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int INC  = PC_INC
) (
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            carry,
    output logic            misaligned
);

    // One extra bit so the wrap-out is visible as the MSB of the sum.
    localparam logic [XLEN:0] INC_EXT = (XLEN+1)'(INC);

    logic [XLEN:0] sum;

    // Full-width add; X on pc propagates untouched to every output.
    always_comb begin
        sum        = {1'b0, pc} + INC_EXT;
        pc_next    = sum[XLEN-1:0];
        carry      = sum[XLEN];
        misaligned = |pc[1:0];
    end

endmodule : pc_inc_comb

// File: rtl/adder_pc4.sv
// Fetch-stage PC incrementer. Combinational pc + INC for the PC mux, plus
// an en-gated registered copy for pipelined fetch with a valid flag that
// marks the first capture after reset.
module adder_pc4
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN,
    parameter int INC  = PC_INC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    input  logic            en,
    output logic [XLEN-1:0] pc_next,
    output logic            carry,
    output logic            misaligned,
    output logic [XLEN-1:0] pc_next_q,
    output logic            carry_q,
    output logic            valid_q
);

    localparam logic [XLEN-1:0] RESET_PC = XLEN'(PC_RESET_VAL);

    pc_inc_comb #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_pc_inc_comb (
        .pc         (pc),
        .pc_next    (pc_next),
        .carry      (carry),
        .misaligned (misaligned)
    );

    // Capture the incremented PC and its carry whenever en is high.
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so ordering of statements cannot create races.
    // NOTE: reset is asynchronous, so a mid-cycle rst_n drop clears the
    // stage immediately and any capture pending for the next edge is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_next_q <= RESET_PC;
            carry_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else if (en) begin
            pc_next_q <= pc_next;
            carry_q   <= carry;
            valid_q   <= 1'b1;
        end
    end

endmodule : adder_pc4

// File: tb/tb_adder_pc4.sv
// Self-checking bench for adder_pc4: directed corner cases followed by a
// randomized run compared against an arithmetic reference model.
module tb_adder_pc4;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        en;
    logic [31:0] pc_next;
    logic        carry;
    logic        misaligned;
    logic [31:0] pc_next_q;
    logic        carry_q;
    logic        valid_q;

    int tests_run;
    int tests_failed;

    // Reference state for the registered stage.
    logic [31:0] exp_q;
    logic        exp_cq;
    logic        exp_v;

    adder_pc4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .en         (en),
        .pc_next    (pc_next),
        .carry      (carry),
        .misaligned (misaligned),
        .pc_next_q  (pc_next_q),
        .carry_q    (carry_q),
        .valid_q    (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain modular arithmetic on a wide integer.
    function automatic logic [31:0] ref_next(input logic [31:0] p);
        longint unsigned s;
        s = longint'(p) + 64'd4;
        return 32'(s % 64'h1_0000_0000);
    endfunction

    function automatic logic ref_carry(input logic [31:0] p);
        longint unsigned s;
        s = longint'(p) + 64'd4;
        return (s > 64'hFFFF_FFFF);
    endfunction

    function automatic logic ref_misaligned(input logic [31:0] p);
        return (p % 4) != 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_comb(input string tag);
        check({tag, ".pc_next"},    64'(pc_next),    64'(ref_next(pc)));
        check({tag, ".carry"},      64'(carry),      64'(ref_carry(pc)));
        check({tag, ".misaligned"}, 64'(misaligned), 64'(ref_misaligned(pc)));
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".pc_next_q"}, 64'(pc_next_q), 64'(exp_q));
        check({tag, ".carry_q"},   64'(carry_q),   64'(exp_cq));
        check({tag, ".valid_q"},   64'(valid_q),   64'(exp_v));
    endtask

    task automatic model_reset();
        exp_q  = 32'h0;
        exp_cq = 1'b0;
        exp_v  = 1'b0;
    endtask

    // Advance to the next rising edge, update the model, sample 1 ns later.
    task automatic clock_and_check(input string tag);
        logic [31:0] p;
        logic        e;
        logic        r;
        p = pc;
        e = en;
        r = rst_n;
        @(posedge clk);
        if (r && e) begin
            exp_q  = ref_next(p);
            exp_cq = ref_carry(p);
            exp_v  = 1'b1;
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        pc    = 32'h0;

        // Reset state and combinational path while reset is held.
        #1;
        check_regs("reset_state");
        check_comb("comb_0x0");
        check(".pc_next_lit", 64'(pc_next), 64'h4);

        pc = 32'h0000_0004; #1; check_comb("comb_0x4");
        check("comb_0x4.lit", 64'(pc_next), 64'h8);
        pc = 32'h0000_000A; #1; check_comb("comb_0xA");
        check("comb_0xA.lit", 64'({misaligned, pc_next}), 64'h1_0000_000E);
        pc = 32'hFFFF_FFFB; #1; check_comb("comb_top_nowrap");
        check("comb_top_nowrap.lit", 64'({carry, pc_next}), 64'h0_FFFF_FFFF);
        pc = 32'hFFFF_FFFC; #1; check_comb("comb_top_wrap");
        check("comb_top_wrap.lit", 64'({carry, pc_next}), 64'h1_0000_0000);
        pc = 32'hFFFF_FFFF; #1; check_comb("comb_all_ones");

        // Reset held with en high and clock running: no capture.
        @(negedge clk);
        pc = 32'h100;
        en = 1'b1;
        clock_and_check("in_reset_edge1");
        clock_and_check("in_reset_edge2");

        // First edge after release captures 0x104.
        @(negedge clk);
        rst_n = 1'b1;
        clock_and_check("first_capture");
        check("first_capture.lit", 64'({valid_q, pc_next_q}), 64'h1_0000_0104);

        // en low: registered stage holds while pc moves.
        @(negedge clk);
        en = 1'b0;
        pc = 32'h200;
        clock_and_check("hold_0x200");
        @(negedge clk);
        pc = 32'h300;
        #1; check_comb("hold_comb_0x300");
        clock_and_check("hold_0x300");
        check("hold.lit", 64'(pc_next_q), 64'h104);

        // en high again: capture 0x304.
        @(negedge clk);
        en = 1'b1;
        clock_and_check("recapture");
        check("recapture.lit", 64'(pc_next_q), 64'h304);

        // Asynchronous reset between edges clears at once.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("async_clear");
        pc = 32'h500;
        #1;
        check_comb("comb_during_reset");
        @(negedge clk);
        rst_n = 1'b1;
        clock_and_check("after_async");

        // Randomized run against the reference model.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                1:       pc = 32'($urandom_range(0, 15));
                default: pc = $urandom;
            endcase
            en = ($urandom_range(0, 3) != 0);
            #1;
            check_comb("rand_comb");
            clock_and_check("rand_reg");
            if ($urandom_range(0, 15) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_regs("rand_async");
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_adder_pc4
